// File: rtl/apb_bridge_param_if.sv
// AHB-lite slave port plus APB3 master port of the parametrised bridge.
// Bridge sees the "slave" modport; the AHB master / APB slaves side uses "master".
interface apb_bridge_param_if #(
  parameter int NUM_SLV = 8,
  parameter int ADDR_W  = 40
);
  // Handshakes: an AHB address phase is taken when hsel & htrans[1] & hready at a rising edge;
  // an APB transfer completes on the ACCESS cycle where pready of the selected slave is high.
  logic                    hsel;
  logic [ADDR_W-1:0]       haddr;
  logic [1:0]              htrans;
  logic                    hwrite;
  logic [2:0]              hsize;
  logic [31:0]             hwdata;
  logic [31:0]             hrdata;
  logic                    hready;
  logic [1:0]              hresp;
  logic [ADDR_W-1:0]       paddr;
  logic                    pwrite;
  logic [31:0]             pwdata;
  logic [NUM_SLV-1:0]      psel;
  logic                    penable;
  logic [NUM_SLV*32-1:0]   prdata_flat;
  logic [NUM_SLV-1:0]      pready;
  logic [NUM_SLV-1:0]      pslverr;
  logic                    timeout_evt;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, prdata_flat, pready, pslverr,
    output hrdata, hready, hresp, paddr, pwrite, pwdata, psel, penable, timeout_evt
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, prdata_flat, pready, pslverr,
    input  hrdata, hready, hresp, paddr, pwrite, pwdata, psel, penable, timeout_evt
  );
endinterface

// File: rtl/apb_bridge_param.sv
// AHB-lite to APB3 bridge: parametrised slave count, wait states, PSLVERR and access timeout.
// One transfer in flight; illegal slave index or size >32 bits gives a two-cycle AHB ERROR.
module apb_bridge_param #(
  parameter int NUM_SLV     = 8,
  parameter int ADDR_W      = 40,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  hclk,
  input  logic                  hrst,
  apb_bridge_param_if.slave     bus,
  output logic [2:0]            state_dbg
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [SEL_W:0]   NUM_SLV_L = (SEL_W + 1)'(NUM_SLV);
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic [SEL_W-1:0]   idx_in, idx_r;
  logic [2:0]         size_r;
  logic               illegal;
  logic [NUM_SLV-1:0] sel_vec;
  logic [31:0]        rdata_sel;
  logic               sel_ready, sel_err;
  logic [CNT_W-1:0]   cnt;
  logic               timeout_hit;

  assign state_dbg = state;

  assign accept = bus.hsel && ((bus.htrans == 2'b10) || (bus.htrans == 2'b11)) && bus.hready;

  always_comb begin
    idx_in = '0;
    if (NUM_SLV > 1) idx_in = bus.haddr[SEL_LSB +: SEL_W];
  end

  assign illegal = ({1'b0, idx_r} >= NUM_SLV_L) || (size_r > 3'b010);
  assign sel_vec = NUM_SLV'(1) << idx_r;

  // Slave response mux driven by the one-hot select, so out-of-range indices read as zero.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_vec[i]) rdata_sel = bus.prdata_flat[32*i +: 32];
    end
  end

  assign sel_ready   = |(bus.pready & sel_vec);
  assign sel_err     = |(bus.pslverr & sel_vec);
  assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.hready  = 1'b1;
    bus.hresp   = 2'b00;
    bus.psel    = '0;
    bus.penable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        bus.hready = 1'b0;
        state_nxt  = illegal ? ST_ERR1 : ST_SETUP;
      end
      ST_SETUP: begin
        bus.hready = 1'b0;
        bus.psel   = sel_vec;
        state_nxt  = ST_ACCESS;
      end
      ST_ACCESS: begin
        bus.hready  = 1'b0;
        bus.psel    = sel_vec;
        bus.penable = 1'b1;
        if (sel_ready)        state_nxt = sel_err ? ST_ERR1 : ST_DONE;
        else if (timeout_hit) state_nxt = ST_ERR1;
      end
      ST_DONE: begin
        state_nxt = accept ? ST_LATCH : ST_IDLE;
      end
      ST_ERR1: begin
        bus.hready = 1'b0;
        bus.hresp  = 2'b01;
        state_nxt  = ST_ERR2;
      end
      ST_ERR2: begin
        bus.hresp = 2'b01;
        state_nxt = accept ? ST_LATCH : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      bus.paddr       <= '0;
      bus.pwrite      <= 1'b0;
      bus.pwdata      <= '0;
      bus.hrdata      <= '0;
      bus.timeout_evt <= 1'b0;
      idx_r           <= '0;
      size_r          <= '0;
      cnt             <= '0;
    end else begin
      if (accept) begin
        bus.paddr  <= bus.haddr;
        bus.pwrite <= bus.hwrite;
        idx_r      <= idx_in;
        size_r     <= bus.hsize;
      end
      // hwdata is valid in the data phase, i.e. the LATCH cycle.
      if (state == ST_LATCH) begin
        bus.pwdata <= bus.hwdata;
        cnt        <= '0;
      end
      if ((state == ST_ACCESS) && !sel_ready) cnt <= cnt + 1'b1;
      if ((state == ST_ACCESS) && sel_ready && !sel_err && !bus.pwrite) bus.hrdata <= rdata_sel;
      bus.timeout_evt <= (state == ST_ACCESS) && !sel_ready && timeout_hit;
    end
  end

endmodule

// File: tb/tb_apb_bridge_param.sv
// Bench for apb_bridge_param (6 slaves, 16-cycle timeout): AHB driver, behavioural APB
// slaves, expected-response queue, one task per scenario and a one-line report.
module tb_apb_bridge_param;
  localparam int NUM_SLV     = 6;
  localparam int ADDR_W      = 40;
  localparam int SEL_LSB     = 12;
  localparam int TIMEOUT_CYC = 16;

  logic       hclk = 1'b0;
  logic       hrst = 1'b1;
  logic [2:0] state_dbg;

  apb_bridge_param_if #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W)) bus ();

  apb_bridge_param #(
    .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .SEL_LSB(SEL_LSB), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .hclk(hclk), .hrst(hrst), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 hclk = ~hclk;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];
  logic [33:0] exp_v;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] prdata_mem [NUM_SLV];

  int   slv_wait = 0;
  logic slv_err = 1'b0;
  int   acc_n = 0;
  int   tevt_cnt = 0;

  always_comb begin
    for (int i = 0; i < NUM_SLV; i++) bus.prdata_flat[32*i +: 32] = prdata_mem[i];
  end

  // APB slaves: unselected slaves answer the opposite way so a wrong select index shows up.
  always @(negedge hclk) begin
    if (bus.penable) acc_n = acc_n + 1;
    else             acc_n = 0;
    if (bus.penable) begin
      bus.pready  = (acc_n > slv_wait) ? bus.psel : ~bus.psel;
      bus.pslverr = slv_err ? bus.psel : ~bus.psel;
    end else begin
      bus.pready  = '0;
      bus.pslverr = '0;
    end
  end

  always @(negedge hclk) if (bus.timeout_evt) tevt_cnt = tevt_cnt + 1;

  // observations of the last transfer
  logic [31:0]        obs_rdata, obs_pwdata;
  logic [1:0]         obs_resp;
  int                 obs_waits;
  logic               obs_err1, obs_pwrite;
  logic [NUM_SLV-1:0] obs_psel_setup, obs_psel_access, obs_psel_any;
  logic [ADDR_W-1:0]  obs_paddr;

  // driver: called at a negedge with hready high; returns at the negedge where hready is high again
  task automatic ahb_xfer(input logic [ADDR_W-1:0] addr, input logic wr, input logic [2:0] size,
                          input logic [31:0] wdata);
    obs_waits = 0; obs_err1 = 1'b0; obs_psel_setup = '0; obs_psel_access = '0;
    obs_psel_any = '0; obs_pwdata = '0; obs_paddr = '0; obs_pwrite = 1'b0;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = addr; bus.hwrite = wr; bus.hsize = size;
    @(negedge hclk);
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = wdata;
    while (bus.hready !== 1'b1 && obs_waits < 100) begin
      obs_waits++;
      obs_err1 = (bus.hresp == 2'b01);
      obs_psel_any |= bus.psel;
      if (bus.psel != 0 && !bus.penable) obs_psel_setup = bus.psel;
      if (bus.psel != 0 && bus.penable && obs_psel_access == 0) begin
        obs_psel_access = bus.psel; obs_pwdata = bus.pwdata;
        obs_paddr = bus.paddr; obs_pwrite = bus.pwrite;
      end
      @(negedge hclk);
    end
    if (obs_waits >= 100) begin
      checks++; failures++;
      $display("FAIL xfer_hang hready stuck low for %0d cycles, required completion", obs_waits);
    end
    obs_rdata = bus.hrdata;
    obs_resp  = bus.hresp;
  endtask

  task automatic test_reset();
    bus.hsel = 0; bus.htrans = 0; bus.haddr = 0; bus.hwrite = 0; bus.hsize = 0; bus.hwdata = 0;
    for (int i = 0; i < NUM_SLV; i++) prdata_mem[i] = $urandom;
    hrst = 1'b1;
    @(negedge hclk); @(negedge hclk);
    checks++;
    if ({bus.hready, bus.hresp, bus.hrdata, bus.psel, bus.penable} !== {1'b1, 2'b00, 32'h0, 6'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_ahb got hready=%b hresp=%b hrdata=%h psel=%h penable=%b, exp 1/00/0/0/0",
               bus.hready, bus.hresp, bus.hrdata, bus.psel, bus.penable);
    end
    checks++;
    if ({bus.paddr, bus.pwrite, bus.pwdata, bus.timeout_evt, state_dbg} !== {40'h0, 1'b0, 32'h0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_apb got paddr=%h pwrite=%b pwdata=%h tevt=%b state=%0d, exp all 0",
               bus.paddr, bus.pwrite, bus.pwdata, bus.timeout_evt, state_dbg);
    end
    hrst = 1'b0;
    @(negedge hclk);
  endtask

  task automatic test_write_zero_wait();
    slv_wait = 0; slv_err = 0;
    exp_q.push_back({2'b00, last_rdata});
    ahb_xfer(40'h00_0000_2010, 1'b1, 3'b010, 32'hA5A5_0001);
    exp_v = exp_q.pop_front();
    checks++;
    if ({obs_resp, obs_rdata} !== exp_v) begin
      failures++; $display("FAIL wr_resp got=%h exp=%h", {obs_resp, obs_rdata}, exp_v);
    end
    checks++;
    if (obs_waits !== 3) begin failures++; $display("FAIL wr_waits got=%0d exp=3", obs_waits); end
    checks++;
    if ({obs_psel_setup, obs_psel_access} !== {6'h04, 6'h04}) begin
      failures++; $display("FAIL wr_psel got setup=%h access=%h exp 04/04", obs_psel_setup, obs_psel_access);
    end
    checks++;
    if ({obs_pwdata, obs_paddr, obs_pwrite} !== {32'hA5A5_0001, 40'h00_0000_2010, 1'b1}) begin
      failures++; $display("FAIL wr_apb got pwdata=%h paddr=%h pwrite=%b", obs_pwdata, obs_paddr, obs_pwrite);
    end
  endtask

  task automatic test_read_wait();
    prdata_mem[5] = 32'h1234_5678;
    slv_wait = 4; slv_err = 0;
    exp_q.push_back({2'b00, 32'h1234_5678});
    ahb_xfer(40'h00_0000_5004, 1'b0, 3'b010, 32'h0);
    last_rdata = 32'h1234_5678;
    exp_v = exp_q.pop_front();
    checks++;
    if ({obs_resp, obs_rdata} !== exp_v) begin
      failures++; $display("FAIL rd_resp got=%h exp=%h", {obs_resp, obs_rdata}, exp_v);
    end
    checks++;
    if (obs_waits !== 7 || obs_psel_access !== 6'h20 || obs_pwrite !== 1'b0) begin
      failures++; $display("FAIL rd_wait got waits=%0d psel=%h pwrite=%b exp 7/20/0",
                           obs_waits, obs_psel_access, obs_pwrite);
    end
  endtask

  task automatic test_slverr();
    slv_wait = 1; slv_err = 1;
    exp_q.push_back({2'b01, last_rdata});
    ahb_xfer(40'h00_0000_3000, 1'b1, 3'b010, 32'hDEAD_BEEF);
    exp_v = exp_q.pop_front();
    checks++;
    if ({obs_resp, obs_rdata} !== exp_v || obs_err1 !== 1'b1 || obs_waits !== 5) begin
      failures++; $display("FAIL slverr_wr got=%h err1=%b waits=%0d exp=%h err1=1 waits=5",
                           {obs_resp, obs_rdata}, obs_err1, obs_waits, exp_v);
    end
    slv_wait = 0;
    exp_q.push_back({2'b01, last_rdata});
    ahb_xfer(40'h00_0000_0000, 1'b0, 3'b010, 32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({obs_resp, obs_rdata} !== exp_v || obs_err1 !== 1'b1 || obs_waits !== 4) begin
      failures++; $display("FAIL slverr_rd got=%h err1=%b waits=%0d exp=%h err1=1 waits=4",
                           {obs_resp, obs_rdata}, obs_err1, obs_waits, exp_v);
    end
    slv_err = 0;
  endtask

  task automatic test_illegal();
    logic [ADDR_W-1:0] addrs [3];
    logic [2:0]        sizes [3];
    addrs[0] = 40'h00_0000_7000; sizes[0] = 3'b010;
    addrs[1] = 40'h00_0000_6008; sizes[1] = 3'b000;
    addrs[2] = 40'h00_0000_1000; sizes[2] = 3'b011;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({2'b01, last_rdata});
      ahb_xfer(addrs[k], 1'b0, sizes[k], 32'h0);
      exp_v = exp_q.pop_front();
      checks++;
      if ({obs_resp, obs_rdata} !== exp_v || obs_waits !== 2 || obs_psel_any !== '0 || obs_err1 !== 1'b1) begin
        failures++;
        $display("FAIL illegal_%0d got=%h waits=%0d psel=%h err1=%b exp=%h waits=2 psel=0 err1=1",
                 k, {obs_resp, obs_rdata}, obs_waits, obs_psel_any, obs_err1, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    int t0;
    slv_wait = 1000; slv_err = 0;
    t0 = tevt_cnt;
    exp_q.push_back({2'b01, last_rdata});
    ahb_xfer(40'h00_0000_4000, 1'b0, 3'b010, 32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({obs_resp, obs_rdata} !== exp_v || obs_waits !== 19 || obs_err1 !== 1'b1) begin
      failures++; $display("FAIL timeout got=%h waits=%0d err1=%b exp=%h waits=19 err1=1",
                           {obs_resp, obs_rdata}, obs_waits, obs_err1, exp_v);
    end
    checks++;
    if (tevt_cnt - t0 !== 1) begin
      failures++; $display("FAIL timeout_evt got pulses=%0d exp=1", tevt_cnt - t0);
    end
    // ready on the last permitted ACCESS cycle completes normally
    slv_wait = 15;
    t0 = tevt_cnt;
    exp_q.push_back({2'b00, prdata_mem[4]});
    ahb_xfer(40'h00_0000_4004, 1'b0, 3'b010, 32'h0);
    last_rdata = prdata_mem[4];
    exp_v = exp_q.pop_front();
    checks++;
    if ({obs_resp, obs_rdata} !== exp_v || obs_waits !== 18 || tevt_cnt - t0 !== 0) begin
      failures++; $display("FAIL timeout_edge got=%h waits=%0d pulses=%0d exp=%h waits=18 pulses=0",
                           {obs_resp, obs_rdata}, obs_waits, tevt_cnt - t0, exp_v);
    end
  endtask

  task automatic test_idle_busy();
    logic [2:0] ctl [3];
    ctl[0] = 3'b100; ctl[1] = 3'b101; ctl[2] = 3'b010;
    for (int k = 0; k < 3; k++) begin
      bus.hsel = ctl[k][2]; bus.htrans = ctl[k][1:0]; bus.haddr = 40'h00_0000_2000;
      @(negedge hclk);
      checks++;
      if ({bus.hready, bus.hresp, bus.psel, state_dbg} !== {1'b1, 2'b00, 6'h0, 3'd0}) begin
        failures++; $display("FAIL idle_busy_%0d got hready=%b hresp=%b psel=%h state=%0d exp 1/00/0/0",
                             k, bus.hready, bus.hresp, bus.psel, state_dbg);
      end
    end
    bus.hsel = 0; bus.htrans = 0;
  endtask

  task automatic test_back_to_back();
    slv_wait = 0; slv_err = 0;
    ahb_xfer(40'h00_0000_1000, 1'b1, 3'b010, 32'h0BAD_F00D);
    exp_q.push_back({2'b00, prdata_mem[3]});
    ahb_xfer(40'h00_0000_3008, 1'b0, 3'b010, 32'h0);
    last_rdata = prdata_mem[3];
    exp_v = exp_q.pop_front();
    checks++;
    if ({obs_resp, obs_rdata} !== exp_v || obs_waits !== 3) begin
      failures++; $display("FAIL b2b_done got=%h waits=%0d exp=%h waits=3", {obs_resp, obs_rdata}, obs_waits, exp_v);
    end
    ahb_xfer(40'h00_0000_7000, 1'b0, 3'b010, 32'h0);
    exp_q.push_back({2'b00, prdata_mem[0]});
    ahb_xfer(40'h00_0000_0010, 1'b0, 3'b001, 32'h0);
    last_rdata = prdata_mem[0];
    exp_v = exp_q.pop_front();
    checks++;
    if ({obs_resp, obs_rdata} !== exp_v || obs_waits !== 3) begin
      failures++; $display("FAIL b2b_err2 got=%h waits=%0d exp=%h waits=3", {obs_resp, obs_rdata}, obs_waits, exp_v);
    end
  endtask

  task automatic test_random();
    int          s;
    logic        wr;
    logic [31:0] wd;
    logic [ADDR_W-1:0] a;
    slv_err = 0;
    for (int k = 0; k < 8; k++) begin
      s = $urandom_range(0, NUM_SLV - 1);
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      slv_wait = $urandom_range(0, 3);
      a = (ADDR_W'(s) << SEL_LSB) | ADDR_W'($urandom_range(0, 1023) * 4);
      if (!wr) last_rdata = prdata_mem[s];
      exp_q.push_back({2'b00, last_rdata});
      ahb_xfer(a, wr, 3'b010, wd);
      exp_v = exp_q.pop_front();
      checks++;
      if ({obs_resp, obs_rdata} !== exp_v || obs_waits !== 3 + slv_wait || obs_psel_access !== 6'(1 << s)) begin
        failures++; $display("FAIL rand_%0d got=%h waits=%0d psel=%h exp=%h waits=%0d slave=%0d",
                             k, {obs_resp, obs_rdata}, obs_waits, obs_psel_access, exp_v, 3 + slv_wait, s);
      end
      if (wr) begin
        checks++;
        if (obs_pwdata !== wd || obs_paddr !== a) begin
          failures++; $display("FAIL rand_wr_%0d got pwdata=%h paddr=%h exp %h/%h", k, obs_pwdata, obs_paddr, wd, a);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    slv_wait = 1000;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 40'h00_0000_2000; bus.hwrite = 1'b0; bus.hsize = 3'b010;
    @(negedge hclk);
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    n = 0;
    while (bus.penable !== 1'b1 && n < 20) begin @(negedge hclk); n++; end
    #2 hrst = 1'b1;
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.hready, state_dbg} !== {6'h0, 1'b0, 1'b1, 3'd0} || n >= 20) begin
      failures++; $display("FAIL reset_mid got psel=%h penable=%b hready=%b state=%0d waited=%0d exp 0/0/1/0",
                           bus.psel, bus.penable, bus.hready, state_dbg, n);
    end
    @(negedge hclk);
    hrst = 1'b0;
    last_rdata = 32'h0;
    @(negedge hclk); @(negedge hclk);
    checks++;
    if ({bus.hready, bus.hresp, bus.psel, bus.hrdata} !== {1'b1, 2'b00, 6'h0, 32'h0}) begin
      failures++; $display("FAIL reset_release got hready=%b hresp=%b psel=%h hrdata=%h exp 1/00/0/0",
                           bus.hready, bus.hresp, bus.psel, bus.hrdata);
    end
    slv_wait = 0;
    exp_q.push_back({2'b00, prdata_mem[1]});
    ahb_xfer(40'h00_0000_1000, 1'b0, 3'b010, 32'h0);
    last_rdata = prdata_mem[1];
    exp_v = exp_q.pop_front();
    checks++;
    if ({obs_resp, obs_rdata} !== exp_v || obs_waits !== 3) begin
      failures++; $display("FAIL after_reset got=%h waits=%0d exp=%h waits=3", {obs_resp, obs_rdata}, obs_waits, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_illegal();
    test_timeout();
    test_idle_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
